// File: rtl/nbbpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the NBBPU datapath with req/ack memory handshakes.
// Optional ack-timeout fault is compiled in with `define NBBPU_CTRL_TIMEOUT_EN.
module nbbpu_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned RETIRE_WIDTH   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    instr_req,
    input  logic                    instr_ack,
    input  logic [15:0]             instr_data,
    output logic [15:0]             instruction,
    input  logic                    zero,
    output logic                    reg_write,
    output logic                    PC_select,
    output logic                    pc_enable,
    output logic                    mem_req,
    output logic                    mem_we,
    input  logic                    mem_ack,
    output logic                    halted,
    output logic                    fault,
    output logic [RETIRE_WIDTH-1:0] retired
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("nbbpu_controller: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT,
        S_FAULT
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             instr_q, instr_d;
    logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
    logic [3:0]              opcode;

    assign opcode      = instr_q[3:0];
    assign instruction = instr_q;
    assign retired     = retired_q;

`ifdef NBBPU_CTRL_TIMEOUT_EN
    logic [15:0] wait_q, wait_d;
    logic        wait_expired;

    // An ack in the limit cycle is checked first, so it always wins over the timeout.
    assign wait_expired = (wait_q == 16'(TIMEOUT_CYCLES - 1));
    assign fault        = (state_q == S_FAULT);
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        instr_req = 1'b0;
        reg_write = 1'b0;
        PC_select = 1'b0;
        pc_enable = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        halted    = 1'b0;
`ifdef NBBPU_CTRL_TIMEOUT_EN
        wait_d    = 16'd0;
`endif
        case (state_q)
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_ack) begin
                    instr_d = instr_data;
                    state_d = S_DECODE;
                end
`ifdef NBBPU_CTRL_TIMEOUT_EN
                else if (wait_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
`endif
            end
            S_DECODE: begin
                case (opcode)
                    4'hA, 4'hB: state_d = S_MEM;
                    4'hF:       state_d = S_HALT;
                    default:    state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                pc_enable = 1'b1;
                reg_write = (opcode <= 4'h9);
                PC_select = (opcode == 4'hC) || ((opcode == 4'hD) && zero);
                retired_d = retired_q + RETIRE_WIDTH'(1);
                state_d   = S_FETCH;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == 4'hB);
                if (mem_ack) begin
                    pc_enable = 1'b1;
                    reg_write = (opcode == 4'hA);
                    retired_d = retired_q + RETIRE_WIDTH'(1);
                    state_d   = S_FETCH;
                end
`ifdef NBBPU_CTRL_TIMEOUT_EN
                else if (wait_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
`endif
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                // FAULT: everything idle until reset
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instr_q   <= 16'h0000;
            retired_q <= '0;
`ifdef NBBPU_CTRL_TIMEOUT_EN
            wait_q    <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
`ifdef NBBPU_CTRL_TIMEOUT_EN
            wait_q    <= wait_d;
`endif
        end
    end

endmodule
